// File: rtl/comp_word_packer.sv
// Packs the compressor byte stream into 32-bit words and buffers them in a first-word-fall-through FIFO.
// Optional build macro COMP_PACKER_MSB_FIRST_EN places the first byte of a word in bits 31:24 instead of 7:0.
module comp_word_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [7:0]       comp_data_i,
    input  logic             comp_data_vld_i,
    input  logic             flush_i,
    output logic [31:0]      word_o,
    output logic             word_vld_o,
    input  logic             word_rdy_i,
    output logic [2:0]       word_bytes_o,
    output logic             word_last_o,
    output logic             overflow_o,
    output logic [LVL_W-1:0] fifo_level_o
);

    localparam int PTR_W = LVL_W - 1;

    typedef enum logic {
        EMPTY,
        FILL
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  lane_reg, lane_next;
    logic [31:0] asm_reg, asm_next;
    logic [31:0] merged_word;
    logic [31:0] lane_word [4];

    logic        push;
    logic [31:0] push_word;
    logic [2:0]  push_bytes;
    logic        push_last;

    // The incoming byte pre-shifted into each lane position; only the lane mapping differs per build.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
`ifdef COMP_PACKER_MSB_FIRST_EN
        localparam int POS = 3 - gi;
`else
        localparam int POS = gi;
`endif
        assign lane_word[gi] = {24'd0, comp_data_i} << (8 * POS);
    end

    assign merged_word = asm_reg | (comp_data_vld_i ? lane_word[lane_reg] : 32'd0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= EMPTY;
            lane_reg  <= 2'd0;
            asm_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
            asm_reg   <= asm_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        asm_next   = asm_reg;
        push       = 1'b0;
        push_word  = merged_word;
        push_bytes = {1'b0, lane_reg} + {2'b00, comp_data_vld_i};
        push_last  = 1'b0;

        if (flush_i) begin
            // A flush cycle's own byte is already folded into merged_word.
            push       = 1'b1;
            push_last  = 1'b1;
            state_next = EMPTY;
            lane_next  = 2'd0;
            asm_next   = 32'd0;
        end else if (comp_data_vld_i) begin
            case (state_reg)
                EMPTY: begin
                    state_next = FILL;
                    lane_next  = 2'd1;
                    asm_next   = merged_word;
                end
                FILL: begin
                    if (lane_reg == 2'd3) begin
                        push       = 1'b1;
                        state_next = EMPTY;
                        lane_next  = 2'd0;
                        asm_next   = 32'd0;
                    end else begin
                        lane_next  = lane_reg + 2'd1;
                        asm_next   = merged_word;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    lane_next  = 2'd0;
                    asm_next   = 32'd0;
                end
            endcase
        end
    end

    logic [31:0]      word_mem  [FIFO_DEPTH];
    logic [2:0]       bytes_mem [FIFO_DEPTH];
    logic             last_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             overflow_reg;
    logic             fifo_full, fifo_pop, push_ok;

    assign fifo_full = (level_reg == LVL_W'(FIFO_DEPTH));
    assign fifo_pop  = (level_reg != '0) && word_rdy_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push && (!fifo_full || fifo_pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            word_mem[wr_ptr_reg]  <= push_word;
            bytes_mem[wr_ptr_reg] <= push_bytes;
            last_mem[wr_ptr_reg]  <= push_last;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push_ok, fifo_pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head fields are gated so an empty FIFO (including right after reset) shows all zeros.
    assign word_vld_o   = (level_reg != '0);
    assign word_o       = word_vld_o ? word_mem[rd_ptr_reg]  : 32'd0;
    assign word_bytes_o = word_vld_o ? bytes_mem[rd_ptr_reg] : 3'd0;
    assign word_last_o  = word_vld_o ? last_mem[rd_ptr_reg]  : 1'b0;
    assign overflow_o   = overflow_reg;
    assign fifo_level_o = level_reg;

endmodule

// File: tb/tb_comp_word_packer.sv
// Self-checking bench for comp_word_packer: directed scenarios plus randomized traffic against a queue model.
module tb_comp_word_packer;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    comp_data;
    logic          comp_data_vld;
    logic          flush;
    logic [31:0]   word;
    logic          word_vld;
    logic          word_rdy;
    logic [2:0]    word_bytes;
    logic          word_last;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    comp_word_packer #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .comp_data_i     (comp_data),
        .comp_data_vld_i (comp_data_vld),
        .flush_i         (flush),
        .word_o          (word),
        .word_vld_o      (word_vld),
        .word_rdy_i      (word_rdy),
        .word_bytes_o    (word_bytes),
        .word_last_o     (word_last),
        .overflow_o      (overflow),
        .fifo_level_o    (fifo_level)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  n;
        logic        l;
    } ent_t;

    logic [7:0] pend[$];
    ent_t       mq[$];
    logic       m_ovf;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [31:0] expect_word(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3);
`ifdef COMP_PACKER_MSB_FIRST_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic model_reset();
        pend.delete();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
    task automatic cycle(input logic [7:0] b, input logic v, input logic f, input logic r);
        logic  pop, was_full, have_push;
        ent_t  e;
        comp_data     = b;
        comp_data_vld = v;
        flush         = f;
        word_rdy      = r;
        pop       = (mq.size() != 0) && r;
        was_full  = (mq.size() == DEPTH);
        have_push = 1'b0;
        e         = '0;
        if (v) pend.push_back(b);
        if (f || pend.size() == 4) begin
            for (int i = 0; i < pend.size(); i++) begin
`ifdef COMP_PACKER_MSB_FIRST_EN
                e.w = e.w | (32'(pend[i]) << (8 * (3 - i)));
`else
                e.w = e.w | (32'(pend[i]) << (8 * i));
`endif
            end
            e.n = 3'(pend.size());
            e.l = f;
            pend.delete();
            have_push = 1'b1;
        end
        if (pop) begin
            $display("word accepted: data=%08h bytes=%0d last=%0b", mq[0].w, mq[0].n, mq[0].l);
            void'(mq.pop_front());
        end
        if (have_push) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; comp_data = 8'h00; comp_data_vld = 1'b0; flush = 1'b0; word_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({word, word_vld, word_bytes, word_last, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got word=%08h vld=%0b bytes=%0d last=%0b ovf=%0b lvl=%0d, want all zero",
                     word, word_vld, word_bytes, word_last, overflow, fifo_level);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (word_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_vld: got %0b want 0", word_vld);
        end
    endtask

    task automatic test_full_word();
        logic [31:0] exp;
        exp = expect_word(8'h11, 8'h22, 8'h33, 8'h44);
        cycle(8'h11, 1, 0, 1);
        cycle(8'h22, 1, 0, 1);
        cycle(8'h33, 1, 0, 1);
        checks++;
        if (word_vld !== 1'b0) begin
            errors++;
            $display("FAIL full_word_early: vld got %0b want 0", word_vld);
        end
        cycle(8'h44, 1, 0, 1);
        checks++;
        if (word_vld !== 1'b1 || word !== exp || word_bytes !== 3'd4 || word_last !== 1'b0) begin
            errors++;
            $display("FAIL full_word: got vld=%0b word=%08h bytes=%0d last=%0b, want 1 %08h 4 0",
                     word_vld, word, word_bytes, word_last, exp);
        end
        cycle(8'h00, 0, 0, 1);
        checks++;
        if (word_vld !== 1'b0) begin
            errors++;
            $display("FAIL full_word_one_cycle: vld got %0b want 0", word_vld);
        end
    endtask

    task automatic test_flush_partial();
        logic [31:0] exp;
        exp = expect_word(8'hAA, 8'hBB, 8'hCC, 8'h00);
        cycle(8'hAA, 1, 0, 0);
        cycle(8'hBB, 1, 0, 0);
        cycle(8'hCC, 1, 1, 0);
        checks++;
        if (word_vld !== 1'b1 || word !== exp || word_bytes !== 3'd3 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL flush_partial: got vld=%0b word=%08h bytes=%0d last=%0b, want 1 %08h 3 1",
                     word_vld, word, word_bytes, word_last, exp);
        end
        exp = expect_word(8'h55, 8'h66, 8'h77, 8'h88);
        cycle(8'h55, 1, 0, 1);
        cycle(8'h66, 1, 0, 0);
        cycle(8'h77, 1, 0, 0);
        cycle(8'h88, 1, 0, 0);
        checks++;
        if (word !== exp || word_bytes !== 3'd4 || word_last !== 1'b0 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL flush_next_stream: got word=%08h bytes=%0d last=%0b lvl=%0d, want %08h 4 0 1",
                     word, word_bytes, word_last, fifo_level, exp);
        end
        cycle(8'h00, 0, 0, 1);
    endtask

    task automatic test_flush_marker();
        cycle(8'h00, 0, 1, 0);
        checks++;
        if (word_vld !== 1'b1 || word !== 32'h0 || word_bytes !== 3'd0 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL flush_marker: got vld=%0b word=%08h bytes=%0d last=%0b, want 1 00000000 0 1",
                     word_vld, word, word_bytes, word_last);
        end
        cycle(8'h00, 0, 1, 0);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL flush_consecutive: level got %0d want 2", fifo_level);
        end
        cycle(8'h00, 0, 0, 1);
        cycle(8'h00, 0, 0, 1);
        checks++;
        if (word_vld !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL marker_drain: vld=%0b lvl=%0d want 0 0", word_vld, fifo_level);
        end
    endtask

    task automatic test_full_with_pop();
        logic [31:0] exp;
        for (int i = 0; i < 19; i++) cycle(8'(8'h80 + i), 1, 0, 0);
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL full_setup: level got %0d want 4", fifo_level);
        end
        cycle(8'h93, 1, 0, 1);
        exp = expect_word(8'h84, 8'h85, 8'h86, 8'h87);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || word !== exp) begin
            errors++;
            $display("FAIL full_with_pop: got lvl=%0d ovf=%0b head=%08h, want 4 0 %08h",
                     fifo_level, overflow, word, exp);
        end
        for (int i = 0; i < 4; i++) cycle(8'h00, 0, 0, 1);
        exp = expect_word(8'h90, 8'h91, 8'h92, 8'h93);
        checks++;
        if (mq.size() != 0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_with_pop_drain: lvl=%0d ovf=%0b want 0 0", fifo_level, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        for (int i = 0; i < 20; i++) begin
            cycle(8'(i + 1), 1, 0, 0);
            if (i == 15) begin
                checks++;
                if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_pre: lvl=%0d ovf=%0b want 4 0", fifo_level, overflow);
                end
            end
        end
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: lvl=%0d ovf=%0b want 4 1", fifo_level, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            exp = expect_word(8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4));
            checks++;
            if (word_vld !== 1'b1 || word !== exp || word_bytes !== 3'd4) begin
                errors++;
                $display("FAIL overflow_drain_%0d: got vld=%0b word=%08h bytes=%0d, want 1 %08h 4",
                         k, word_vld, word, word_bytes, exp);
            end
            cycle(8'h00, 0, 0, 1);
        end
        checks++;
        if (word_vld !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: vld=%0b ovf=%0b want 0 1", word_vld, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) cycle(8'(8'hE0 + i), 1, 0, 0);
        comp_data_vld = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({word, word_vld, word_bytes, word_last, overflow, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_midstream: got word=%08h vld=%0b bytes=%0d last=%0b ovf=%0b lvl=%0d, want all zero",
                     word, word_vld, word_bytes, word_last, overflow, fifo_level);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp = expect_word(8'h01, 8'h02, 8'h03, 8'h04);
        for (int i = 1; i <= 4; i++) cycle(8'(i), 1, 0, 0);
        checks++;
        if (word !== exp || word_bytes !== 3'd4 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL reset_no_residue: got word=%08h bytes=%0d lvl=%0d, want %08h 4 1",
                     word, word_bytes, fifo_level, exp);
        end
        cycle(8'h00, 0, 0, 1);
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 2000; i++) begin
            r = ((i / 200) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            cycle(8'($urandom), $urandom_range(3) != 0, $urandom_range(15) == 0, r);
            checks++;
            if (word_vld !== (mq.size() != 0) || fifo_level !== LW'(mq.size()) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_status @%0d: got vld=%0b lvl=%0d ovf=%0b, want %0b %0d %0b",
                         i, word_vld, fifo_level, overflow, mq.size() != 0, mq.size(), m_ovf);
            end
            if (mq.size() != 0) begin
                checks++;
                if (word !== mq[0].w || word_bytes !== mq[0].n || word_last !== mq[0].l) begin
                    errors++;
                    $display("FAIL random_head @%0d: got word=%08h bytes=%0d last=%0b, want %08h %0d %0b",
                             i, word, word_bytes, word_last, mq[0].w, mq[0].n, mq[0].l);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush_partial();
        test_flush_marker();
        test_full_with_pop();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
